// File: rtl/dtw_sched.sv
// Job sequencer between the control registers and dtw_core: core reset pulse,
// start handshake, stream counters, watchdog and sticky done/error status.
module dtw_sched #(
  parameter int SQG_SIZE    = 250,
  parameter int MAX_REF_LEN = 65536,
  parameter int RST_CYCLES  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [31:0] cmd_len,
  input  logic        clear_done,
  output logic        core_rst,
  output logic        core_start,
  output logic        core_mode,
  output logic [31:0] core_ref_len,
  input  logic        core_running,
  input  logic        src_fifo_empty,
  input  logic        src_fifo_rden,
  input  logic        sink_fifo_wren,
  output logic        sts_busy,
  output logic        sts_done,
  output logic        sts_err_timeout,
  output logic        sts_err_len,
  output logic [31:0] sts_src_cnt,
  output logic [31:0] sts_sink_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RESET    = 3'd1;
  localparam logic [2:0] S_ARM      = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_RUN = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;
  localparam logic [2:0] S_ABORT    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [2:0]     state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           init_q, init_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           core_rst_q, core_rst_d;
  logic           core_start_q, core_start_d;
  logic           core_mode_q, core_mode_d;
  logic [31:0]    core_ref_len_q, core_ref_len_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tmo_q, tmo_d;
  logic           elen_q, elen_d;
  logic [31:0]    src_q, src_d;
  logic [31:0]    sink_q, sink_d;

  logic accept, illegal, wd_active, stay;

  always_comb begin
    state_d        = state_q;
    rcnt_d         = rcnt_q;
    wd_d           = wd_q;
    core_mode_d    = core_mode_q;
    core_ref_len_d = core_ref_len_q;
    done_d         = done_q & ~clear_done;
    tmo_d          = tmo_q & ~clear_done;
    elen_d         = elen_q & ~clear_done;
    src_d          = src_q;
    sink_d         = sink_q;

    accept  = cmd_valid && cmd_ready_q;
    illegal = !cmd_mode && ((cmd_len == 32'd0) || (cmd_len > 32'(MAX_REF_LEN)));

    if (state_q != S_IDLE) begin
      if (src_fifo_rden && (src_q != '1))   src_d  = src_q + 32'd1;
      if (sink_fifo_wren && (sink_q != '1)) sink_d = sink_q + 32'd1;
    end

    case (state_q)
      S_IDLE: if (accept) begin
        core_mode_d    = cmd_mode;
        core_ref_len_d = cmd_mode ? 32'(SQG_SIZE) : cmd_len;
        src_d          = '0;
        sink_d         = '0;
        done_d         = 1'b0;
        tmo_d          = 1'b0;
        elen_d         = illegal;
        state_d        = illegal ? S_DONE : S_RESET;
      end
      S_RESET, S_ABORT: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1))
          state_d = (state_q == S_RESET) ? S_ARM : S_DONE;
        else
          rcnt_d = rcnt_q + 1'b1;
      end
      S_ARM:      if (!src_fifo_empty) state_d = S_START;
      S_START:    state_d = S_WAIT_RUN;
      S_WAIT_RUN: if (core_running) state_d = S_RUN;
      S_RUN: if (!core_running) begin
        state_d = S_DONE;
        // Check includes any strobe landing in the same cycle running drops.
        if (core_mode_q ? ((src_d != 32'(SQG_SIZE)) || (sink_d != 32'd1))
                        : ((src_d != core_ref_len_q) || (sink_d != 32'd0)))
          elen_d = 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wd_active = (state_q == S_ARM) || (state_q == S_WAIT_RUN) || (state_q == S_RUN);
    stay      = (state_d == state_q) && !src_fifo_rden && !sink_fifo_wren;
    if (!stay || !wd_active) begin
      wd_d = '0;
    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
      wd_d    = '0;
      tmo_d   = 1'b1;
      state_d = S_ABORT;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    if (state_d != state_q) rcnt_d = '0;

    // First cycle out of reset still looks like reset to the register file.
    init_d       = 1'b0;
    core_rst_d   = init_q || (state_d == S_RESET) || (state_d == S_ABORT);
    cmd_ready_d  = !init_q && (state_d == S_IDLE) && (state_q == S_IDLE);
    core_start_d = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rcnt_q         <= '0;
      wd_q           <= '0;
      init_q         <= 1'b1;
      cmd_ready_q    <= 1'b0;
      core_rst_q     <= 1'b1;
      core_start_q   <= 1'b0;
      core_mode_q    <= 1'b0;
      core_ref_len_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tmo_q          <= 1'b0;
      elen_q         <= 1'b0;
      src_q          <= '0;
      sink_q         <= '0;
    end else begin
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      wd_q           <= wd_d;
      init_q         <= init_d;
      cmd_ready_q    <= cmd_ready_d;
      core_rst_q     <= core_rst_d;
      core_start_q   <= core_start_d;
      core_mode_q    <= core_mode_d;
      core_ref_len_q <= core_ref_len_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      tmo_q          <= tmo_d;
      elen_q         <= elen_d;
      src_q          <= src_d;
      sink_q         <= sink_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign core_rst        = core_rst_q;
  assign core_start      = core_start_q;
  assign core_mode       = core_mode_q;
  assign core_ref_len    = core_ref_len_q;
  assign sts_busy        = busy_q;
  assign sts_done        = done_q;
  assign sts_err_timeout = tmo_q;
  assign sts_err_len     = elen_q;
  assign sts_src_cnt     = src_q;
  assign sts_sink_cnt    = sink_q;

endmodule

// File: tb/tb_dtw_sched.sv
// Directed bench for dtw_sched: query/load jobs, illegal lengths, stalls,
// back-to-back commands and mid-job reset.
module tb_dtw_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_mode, clear_done;
  logic [31:0] cmd_len;
  logic        core_rst, core_start, core_mode, core_running;
  logic [31:0] core_ref_len;
  logic        src_fifo_empty, src_fifo_rden, sink_fifo_wren;
  logic        sts_busy, sts_done, sts_err_timeout, sts_err_len;
  logic [31:0] sts_src_cnt, sts_sink_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dtw_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .clear_done(clear_done),
    .core_rst(core_rst), .core_start(core_start), .core_mode(core_mode),
    .core_ref_len(core_ref_len), .core_running(core_running),
    .src_fifo_empty(src_fifo_empty), .src_fifo_rden(src_fifo_rden),
    .sink_fifo_wren(sink_fifo_wren), .sts_busy(sts_busy), .sts_done(sts_done),
    .sts_err_timeout(sts_err_timeout), .sts_err_len(sts_err_len),
    .sts_src_cnt(sts_src_cnt), .sts_sink_cnt(sts_sink_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_cmd(input logic mode, input logic [31:0] len);
    cmd_mode  = mode;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    chk("wait_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 100) begin step(); n++; end
    chk("wait_start", 32'(core_start), 32'd1);
  endtask

  // Core model from WAIT_RUN: run, stream reads then writes, drop running.
  // Returns in the DONE cycle.
  task automatic do_job(input int nrd, input int nwr);
    core_running = 1'b1;
    step();
    for (int i = 0; i < nrd; i++) begin src_fifo_rden = 1'b1; step(); end
    src_fifo_rden = 1'b0;
    for (int i = 0; i < nwr; i++) begin sink_fifo_wren = 1'b1; step(); end
    sink_fifo_wren = 1'b0;
    core_running = 1'b0;
    step();
  endtask

  task automatic count_core_rst(input string tag);
    int n = 0;
    while (core_rst && n < 20) begin n++; step(); end
    chk(tag, 32'(n), 32'd4);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = '0; clear_done = 1'b0;
    core_running = 1'b0; src_fifo_empty = 1'b1; src_fifo_rden = 1'b0; sink_fifo_wren = 1'b0;

    // Reset values
    step(); step(); step();
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(sts_busy), 32'd0);
    chk("rst_done", 32'(sts_done), 32'd0);
    chk("rst_src", sts_src_cnt, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_core_rst", 32'(core_rst), 32'd1);
    chk("post_rst_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("run_core_rst", 32'(core_rst), 32'd0);
    chk("run_ready", 32'(cmd_ready), 32'd1);

    // Query job, FIFO pre-filled
    src_fifo_empty = 1'b0;
    accept_cmd(1'b1, 32'd7);
    chk("q_busy", 32'(sts_busy), 32'd1);
    chk("q_ready_low", 32'(cmd_ready), 32'd0);
    chk("q_mode", 32'(core_mode), 32'd1);
    chk("q_ref_len", core_ref_len, 32'd250);
    count_core_rst("q_rst_cycles");
    chk("q_arm_no_start", 32'(core_start), 32'd0);
    step();
    chk("q_start", 32'(core_start), 32'd1);
    step();
    chk("q_start_one_cycle", 32'(core_start), 32'd0);
    do_job(250, 1);
    chk("q_done_not_yet", 32'(sts_done), 32'd0);
    step();
    chk("q_done", 32'(sts_done), 32'd1);
    chk("q_ready_lag", 32'(cmd_ready), 32'd0);
    chk("q_busy_clr", 32'(sts_busy), 32'd0);
    step();
    chk("q_ready", 32'(cmd_ready), 32'd1);
    chk("q_src", sts_src_cnt, 32'd250);
    chk("q_sink", sts_sink_cnt, 32'd1);
    chk("q_err_len", 32'(sts_err_len), 32'd0);
    chk("q_err_tmo", 32'(sts_err_timeout), 32'd0);

    // Load job with short read count
    accept_cmd(1'b0, 32'd1000);
    chk("l_ref_len", core_ref_len, 32'd1000);
    chk("l_done_cleared", 32'(sts_done), 32'd0);
    wait_start();
    step();
    do_job(999, 0);
    step();
    chk("l_done", 32'(sts_done), 32'd1);
    chk("l_err_len", 32'(sts_err_len), 32'd1);
    chk("l_src", sts_src_cnt, 32'd999);
    chk("l_sink", sts_sink_cnt, 32'd0);
    chk("l_err_tmo", 32'(sts_err_timeout), 32'd0);
    wait_ready();

    // Illegal lengths: zero, then MAX+1
    accept_cmd(1'b0, 32'd0);
    chk("z_err_len", 32'(sts_err_len), 32'd1);
    chk("z_core_rst", 32'(core_rst), 32'd0);
    step();
    chk("z_done", 32'(sts_done), 32'd1);
    chk("z_core_start", 32'(core_start), 32'd0);
    chk("z_core_rst2", 32'(core_rst), 32'd0);
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    chk("clr_done", 32'(sts_done), 32'd0);
    chk("clr_err_len", 32'(sts_err_len), 32'd0);
    wait_ready();
    accept_cmd(1'b0, 32'd65537);
    chk("m_core_rst", 32'(core_rst), 32'd0);
    step();
    chk("m_done", 32'(sts_done), 32'd1);
    chk("m_err_len", 32'(sts_err_len), 32'd1);
    chk("m_core_start", 32'(core_start), 32'd0);
    wait_ready();

    // Stall in ARM: FIFO empty
    src_fifo_empty = 1'b1;
    accept_cmd(1'b1, 32'd0);
    step(); step(); step();
    chk("sa_rst_end", 32'(core_rst), 32'd1);
    step();
    chk("sa_arm", 32'(core_rst), 32'd0);
    for (int i = 0; i < 1023; i++) step();
    chk("sa_no_tmo_yet", 32'(sts_err_timeout), 32'd0);
    chk("sa_no_abort_yet", 32'(core_rst), 32'd0);
    step();
    chk("sa_tmo", 32'(sts_err_timeout), 32'd1);
    count_core_rst("sa_abort_rst");
    chk("sa_done_not_yet", 32'(sts_done), 32'd0);
    step();
    chk("sa_done", 32'(sts_done), 32'd1);
    chk("sa_err_len", 32'(sts_err_len), 32'd0);
    wait_ready();

    // Stall in RUN
    src_fifo_empty = 1'b0;
    accept_cmd(1'b1, 32'd0);
    wait_start();
    step();
    core_running = 1'b1;
    step();
    n = 0;
    while (!sts_err_timeout && n < 2000) begin step(); n++; end
    chk("sr_tmo_cycles", 32'(n), 32'd1024);
    count_core_rst("sr_abort_rst");
    step();
    chk("sr_done", 32'(sts_done), 32'd1);
    chk("sr_err_len", 32'(sts_err_len), 32'd0);
    core_running = 1'b0;
    wait_ready();

    // Back-to-back: cmd_valid held high, clear_done collides with DONE
    cmd_mode = 1'b1;
    cmd_valid = 1'b1;
    step();
    count_core_rst("bb_rst_cycles");
    wait_start();
    step();
    do_job(250, 1);
    chk("bb_busy_in_done", 32'(sts_busy), 32'd1);
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    chk("bb_set_wins", 32'(sts_done), 32'd1);
    chk("bb_not_ready", 32'(cmd_ready), 32'd0);
    chk("bb_idle", 32'(sts_busy), 32'd0);
    step();
    chk("bb_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bb_second_accept", 32'(sts_busy), 32'd1);
    chk("bb_second_rst", 32'(core_rst), 32'd1);
    chk("bb_done_cleared", 32'(sts_done), 32'd0);

    // Reset mid-RUN
    wait_start();
    step();
    core_running = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin src_fifo_rden = 1'b1; step(); end
    src_fifo_rden = 1'b0;
    chk("mr_src_before", sts_src_cnt, 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    core_running = 1'b0;
    chk("mr_busy", 32'(sts_busy), 32'd0);
    chk("mr_core_rst", 32'(core_rst), 32'd1);
    chk("mr_ready", 32'(cmd_ready), 32'd0);
    chk("mr_src", sts_src_cnt, 32'd0);
    chk("mr_done", 32'(sts_done), 32'd0);
    chk("mr_mode", 32'(core_mode), 32'd0);
    chk("mr_ref_len", core_ref_len, 32'd0);
    wait_ready();
    accept_cmd(1'b1, 32'd0);
    wait_start();
    step();
    do_job(250, 1);
    step();
    chk("fr_done", 32'(sts_done), 32'd1);
    chk("fr_src", sts_src_cnt, 32'd250);
    chk("fr_sink", sts_sink_cnt, 32'd1);
    chk("fr_err_len", 32'(sts_err_len), 32'd0);
    chk("fr_err_tmo", 32'(sts_err_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
